// File: rtl/decoder_3_8_seq.sv
`default_nettype none
// ============================================================================
// Module      : decoder_3_8_seq
// Description : Registered 3-to-8 one-hot decoder with valid/ready input and
//               a programmable output pulse length plus completion strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_3_8_seq #(
    parameter int CODE_W = 3,
    parameter int HOLD_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_W-1:0]      in_code,
    input  logic [HOLD_W-1:0]      hold_len,
    input  logic                   abort,
    output logic [(2**CODE_W)-1:0] y,
    output logic                   y_valid,
    output logic                   done
);

    localparam int                N_OUT      = 2**CODE_W;
    localparam logic [HOLD_W-1:0] c_HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] c_HOLD_0   = '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    logic [HOLD_W-1:0]   r_cnt;
    logic [CODE_W-1:0]   r_code;
    logic [N_OUT-1:0]    r_y;
    logic                r_y_valid;
    logic                r_done;

    logic [N_OUT-1:0]    w_dec;
    logic [HOLD_W-1:0]   w_load;

    assign w_dec  = {{(N_OUT-1){1'b0}}, 1'b1} << in_code;
    // A zero length still yields a single-cycle pulse.
    assign w_load = (hold_len == c_HOLD_0) ? c_HOLD_0 : (hold_len - c_HOLD_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_code    <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state   <= S_HOLD;
                        r_code    <= in_code;
                        r_cnt     <= w_load;
                        r_y       <= w_dec;
                        r_y_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // abort beats normal completion, so no done on a cancelled last cycle
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_y       <= '0;
                        r_y_valid <= 1'b0;
                    end else if (r_cnt == c_HOLD_0) begin
                        r_state   <= S_IDLE;
                        r_y       <= '0;
                        r_y_valid <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_HOLD_ONE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_y       <= '0;
                    r_y_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign y        = r_y;
    assign y_valid  = r_y_valid;
    assign done     = r_done;

endmodule
`default_nettype wire
